// File: rtl/led_pio_pwm_pkg.sv
// Shared definitions for the LED PIO with blink and PWM dimming.
//   reg_addr_e       : word addresses of the Avalon-MM register map
//   STATUS_* offsets : bit positions of the fields in the STATUS register
package led_pio_pwm_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_OUTSET  = 3'd1,
    ADDR_OUTCLR  = 3'd2,
    ADDR_BLINKEN = 3'd3,
    ADDR_PERIOD  = 3'd4,
    ADDR_DUTY    = 3'd5,
    ADDR_STATUS  = 3'd6,
    ADDR_RSVD    = 3'd7
  } reg_addr_e;

  // STATUS = {15'b0, blink_phase, pwm_cnt zero-extended to 16 bits}
  localparam int STATUS_PWM_LSB   = 0;
  localparam int STATUS_PWM_W     = 16;
  localparam int STATUS_PHASE_BIT = 16;

endpackage

// File: rtl/led_pio_timebase.sv
// Timebase for the LED PIO: blink prescaler/phase and PWM counter with a
// frame-aligned duty shadow.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   period        : blink half-period P (phase toggles every P+1 clocks)
//   duty          : requested PWM duty, taken into use at the next frame start
//   period_wr     : one-cycle strobe, PERIOD register is being written
//   blink_phase   : current blink phase
//   pwm_on        : PWM gate for the current cycle
//   pwm_cnt       : free-running PWM counter value
module led_pio_timebase #(
  parameter int PRESCALE_BITS = 24,
  parameter int PWM_BITS      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [PRESCALE_BITS-1:0] period,
  input  logic [PWM_BITS-1:0]      duty,
  input  logic                     period_wr,
  output logic                     blink_phase,
  output logic                     pwm_on,
  output logic [PWM_BITS-1:0]      pwm_cnt
);

  logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
  logic                     phase_q, phase_d;
  logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0]      duty_act_q, duty_act_d;

  always_comb begin
    pre_cnt_d  = pre_cnt_q + 1'b1;
    phase_d    = phase_q;
    // A PERIOD write restarts the half-period and takes priority over a
    // coincident wrap, so the phase never toggles on the write edge.
    if (period_wr) begin
      pre_cnt_d = '0;
    end else if (pre_cnt_q == period) begin
      pre_cnt_d = '0;
      phase_d   = ~phase_q;
    end

    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    duty_act_d = duty_act_q;
    // Duty is only adopted on the wrap to 0 so a frame never mixes two duties.
    if (pwm_cnt_q == '1) begin
      duty_act_d = duty;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q  <= '0;
      phase_q    <= 1'b0;
      pwm_cnt_q  <= '0;
      duty_act_q <= '1;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      phase_q    <= phase_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_act_q <= duty_act_d;
    end
  end

  // All-ones duty must be fully on, which the compare alone cannot reach.
  assign pwm_on      = (pwm_cnt_q < duty_act_q) | (&duty_act_q);
  assign blink_phase = phase_q;
  assign pwm_cnt     = pwm_cnt_q;

endmodule

// File: rtl/led_pio_pwm.sv
// Avalon-MM output PIO for board LEDs with atomic set/clear, per-channel
// blink and global PWM dimming.
// Bus handshake: zero-wait-state slave. A write happens on every rising edge
// where chipselect=1 and write_n=0; readdata is combinational from address
// and is valid in the same cycle. There is no backpressure.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   address       : register word address (see reg_addr_e)
//   chipselect    : slave select
//   write_n       : active-low write strobe
//   writedata     : write data, bits above a register's width ignored
//   readdata      : read data, zero-extended
//   out_port      : registered LED outputs
module led_pio_pwm
  import led_pio_pwm_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int               PRESCALE_BITS = 24,
  parameter int               PWM_BITS      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]         data_q, data_d;
  logic [WIDTH-1:0]         blinken_q, blinken_d;
  logic [PRESCALE_BITS-1:0] period_q, period_d;
  logic [PWM_BITS-1:0]      duty_q, duty_d;
  logic [WIDTH-1:0]         out_q, out_d;

  logic                     wr;
  logic                     period_wr;
  logic [WIDTH-1:0]         wd_w;
  logic                     blink_phase;
  logic                     pwm_on;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic                     unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd_w      = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  led_pio_timebase #(
    .PRESCALE_BITS (PRESCALE_BITS),
    .PWM_BITS      (PWM_BITS)
  ) u_timebase (
    .clk         (clk),
    .reset_n     (reset_n),
    .period      (period_q),
    .duty        (duty_q),
    .period_wr   (period_wr),
    .blink_phase (blink_phase),
    .pwm_on      (pwm_on),
    .pwm_cnt     (pwm_cnt)
  );

  // Register file write decode.
  always_comb begin
    data_d    = data_q;
    blinken_d = blinken_q;
    period_d  = period_q;
    duty_d    = duty_q;
    period_wr = 1'b0;
    if (wr) begin
      case (reg_addr_e'(address))
        ADDR_DATA:    data_d    = wd_w;
        ADDR_OUTSET:  data_d    = data_q | wd_w;
        ADDR_OUTCLR:  data_d    = data_q & ~wd_w;
        ADDR_BLINKEN: blinken_d = wd_w;
        ADDR_PERIOD: begin
          period_d  = writedata[PRESCALE_BITS-1:0];
          period_wr = 1'b1;
        end
        ADDR_DUTY:    duty_d    = writedata[PWM_BITS-1:0];
        default: ;
      endcase
    end
  end

  // Blink-enabled channels are gated by the phase; all channels by PWM.
  always_comb begin
    out_d = data_q & (~blinken_q | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= RESET_VALUE;
      blinken_q <= '0;
      period_q  <= '1;
      duty_q    <= '1;
      out_q     <= RESET_VALUE;
    end else begin
      data_q    <= data_d;
      blinken_q <= blinken_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      out_q     <= out_d;
    end
  end

  assign out_port = out_q;

  // Read mux; OUTSET, OUTCLR and the reserved address read as zero.
  always_comb begin
    readdata = '0;
    case (reg_addr_e'(address))
      ADDR_DATA:    readdata[WIDTH-1:0]         = data_q;
      ADDR_BLINKEN: readdata[WIDTH-1:0]         = blinken_q;
      ADDR_PERIOD:  readdata[PRESCALE_BITS-1:0] = period_q;
      ADDR_DUTY:    readdata[PWM_BITS-1:0]      = duty_q;
      ADDR_STATUS: begin
        readdata[STATUS_PWM_LSB +: PWM_BITS] = pwm_cnt;
        readdata[STATUS_PHASE_BIT]           = blink_phase;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_pio_pwm.sv
// Directed bench for led_pio_pwm: an 8-bit instance (RESET_VALUE=8'hA5) plus
// 1-bit and 32-bit instances sharing the same bus inputs.
module tb_led_pio_pwm;
  import led_pio_pwm_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd8, rd1, rd32;
  logic [7:0]  out8;
  logic [0:0]  out1;
  logic [31:0] out32;

  always #5 clk = ~clk;

  // Edges since reset release; the PWM counter must equal this mod 256.
  int edge_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  led_pio_pwm #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd8), .out_port(out8));

  led_pio_pwm #(.WIDTH(1), .RESET_VALUE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .out_port(out1));

  led_pio_pwm #(.WIDTH(32), .RESET_VALUE(32'h8000_0001)) dut32 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd32), .out_port(out32));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Called between a falling and the next rising edge; the write lands on
  // that rising edge and the task returns at the following falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    address    = a;
    chipselect = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] pcnt();
    return 32'(edge_cnt % 256);
  endfunction

  // ---------------- stimulus ----------------
  int hi;
  int bad;
  logic [31:0] e;

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 1: reset values
    repeat (10) @(negedge clk);
    check("rst_out8", {24'h0, out8}, 32'hA5);
    check("rst_out1", {31'h0, out1}, 32'h1);
    check("rst_out32", out32, 32'h8000_0001);
    bus_read(ADDR_DATA);   check("rst_data", rd8, 32'hA5);
    bus_read(ADDR_RSVD);   check("rd_addr7", rd8, 32'h0);
    bus_read(ADDR_STATUS); check("status_pwm_cnt", rd8 & 32'hFFFF, pcnt());

    // 2: DATA / OUTSET / OUTCLR
    bus_write(ADDR_DATA,   32'h0F);
    bus_write(ADDR_OUTSET, 32'hF0);
    bus_write(ADDR_OUTCLR, 32'h3C);
    check("out_1edge_old", {24'h0, out8}, 32'hFF);
    bus_read(ADDR_DATA);   check("data_c3", rd8, 32'hC3);
    bus_read(ADDR_OUTSET); check("rd_outset", rd8, 32'h0);
    bus_read(ADDR_OUTCLR); check("rd_outclr", rd8, 32'h0);
    @(negedge clk);
    check("out_c3", {24'h0, out8}, 32'hC3);

    // 3: blink with P=3, bit0 toggles every 4 clocks
    bus_write(ADDR_DATA,    32'hFF);
    bus_write(ADDR_BLINKEN, 32'h01);
    bus_write(ADDR_PERIOD,  32'd3);
    for (int k = 1; k <= 16; k++)
      exp_q.push_back((((k - 1) / 4) % 2 == 1) ? 32'hFF : 32'hFE);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("blink_k%0d", k), {24'h0, out8}, e);
    end
    // Rewrite PERIOD mid-count (pre_cnt==2): next toggle P+1 clocks later.
    repeat (2) @(negedge clk);
    bus_write(ADDR_PERIOD, 32'd5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus_read(ADDR_STATUS);
      check($sformatf("rewr_phase_k%0d", k), {31'h0, rd8[16]}, (k >= 6) ? 32'h1 : 32'h0);
      check($sformatf("rewr_out_k%0d", k), {24'h0, out8}, (k >= 7) ? 32'hFF : 32'hFE);
    end
    // PERIOD write on the wrap edge: no toggle, count restarts.
    repeat (3) @(negedge clk);
    bus_write(ADDR_PERIOD, 32'd5);
    bus_read(ADDR_STATUS); check("wrwin_phase0", {31'h0, rd8[16]}, 32'h1);
    repeat (5) @(negedge clk);
    bus_read(ADDR_STATUS); check("wrwin_phase5", {31'h0, rd8[16]}, 32'h1);
    @(negedge clk);
    bus_read(ADDR_STATUS); check("wrwin_phase6", {31'h0, rd8[16]}, 32'h0);
    bus_write(ADDR_BLINKEN, 32'h0);
    @(negedge clk);

    // 4: PWM duty shadowing
    for (int i = 0; i < 300 && pcnt() != 32'd100; i++) @(negedge clk);
    bus_read(ADDR_STATUS); check("pwm_cnt_100", rd8 & 32'hFFFF, 32'd100);
    bus_write(ADDR_DUTY, 32'd64);
    bus_read(ADDR_DUTY); check("rd_duty64", rd8, 32'd64);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (out8 !== 8'hFF) bad++;
      if (pcnt() == 0) break;
      @(negedge clk);
    end
    check("duty_old_holds", 32'(bad), 32'd0);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (out8 === 8'hFF) hi++;
      if (pcnt() == 32'd64) check("pwm_on_64", {24'h0, out8}, 32'hFF);
      if (pcnt() == 32'd65) check("pwm_off_65", {24'h0, out8}, 32'h00);
    end
    check("duty64_high", 32'(hi), 32'd64);

    bus_write(ADDR_DUTY, 32'd0);
    for (int i = 0; i < 300 && pcnt() != 0; i++) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (out8 !== 8'h00) hi++;
    end
    check("duty0_high", 32'(hi), 32'd0);

    bus_write(ADDR_DUTY, 32'd255);
    for (int i = 0; i < 300 && pcnt() != 0; i++) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (out8 === 8'hFF) hi++;
    end
    check("duty255_high", 32'(hi), 32'd256);

    // 5: asynchronous reset mid-frame with blink active
    bus_write(ADDR_PERIOD,  32'd3);
    bus_write(ADDR_BLINKEN, 32'h0F);
    bus_write(ADDR_DATA,    32'h3C);
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_out8", {24'h0, out8}, 32'hA5);
    check("async_out1", {31'h0, out1}, 32'h1);
    check("async_out32", out32, 32'h8000_0001);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(ADDR_STATUS);  check("rel_status", rd8, 32'h0);
    bus_read(ADDR_PERIOD);  check("rel_period", rd8, 32'h00FF_FFFF);
    bus_read(ADDR_DUTY);    check("rel_duty", rd8, 32'hFF);
    bus_read(ADDR_BLINKEN); check("rel_blinken", rd8, 32'h0);
    repeat (3) @(negedge clk);
    check("rel_out8", {24'h0, out8}, 32'hA5);

    // 6: width extremes, top-bit set/clear, truncation and zero-extension
    bus_write(ADDR_DATA, 32'hFFFF_FF00);
    bus_read(ADDR_DATA);
    check("w8_trunc", rd8, 32'h0);
    check("w1_trunc", rd1, 32'h0);
    check("w32_data", rd32, 32'hFFFF_FF00);
    bus_write(ADDR_OUTSET, 32'h8000_0001);
    bus_read(ADDR_DATA);
    check("w8_set", rd8, 32'h01);
    check("w1_set", rd1, 32'h1);
    check("w32_set", rd32, 32'hFFFF_FF01);
    bus_write(ADDR_OUTCLR, 32'h8000_0000);
    bus_read(ADDR_DATA);
    check("w32_clr_top", rd32, 32'h7FFF_FF01);
    check("w1_clr_high", rd1, 32'h1);
    @(negedge clk);
    check("w32_out", out32, 32'h7FFF_FF01);
    check("w1_out_set", {31'h0, out1}, 32'h1);
    bus_write(ADDR_OUTCLR, 32'h0000_0001);
    bus_read(ADDR_DATA);
    check("w1_clr", rd1, 32'h0);
    @(negedge clk);
    check("w1_out_clr", {31'h0, out1}, 32'h0);
    check("w8_out_clr", {24'h0, out8}, 32'h0);
    bus_write(ADDR_BLINKEN, 32'hFFFF_FFFF);
    bus_read(ADDR_BLINKEN);
    check("w8_blinken_zx", rd8, 32'hFF);
    check("w1_blinken_zx", rd1, 32'h1);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
